quadrature_decoder: RTL and testbench
=====================================

QUADRATURE_DECODER -- requirements
Module: quadrature_decoder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer flops per encoder input (legal 2..4).
REQ-002 SHALL have parameter FILTER_LEN, default 4, meaning consecutive cycles a synchronized level must persist before acceptance (legal 1..255).
REQ-003 SHALL have one clock and an asynchronous, active-low reset: port clk, input, 1 bit, sole clock, all flops on rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have ports enc_a and enc_b, input, 1 bit each, raw asynchronous encoder channels.
REQ-006 SHALL have port en, input, 1 bit, pulse-output enable.
REQ-007 SHALL have port increase, output, 1 bit, one-cycle pulse per forward step, for direct connection to the downstream up/down counter.
REQ-008 SHALL have port decrease, output, 1 bit, one-cycle pulse per reverse step.
REQ-009 SHALL have port error, output, 1 bit, one-cycle pulse on illegal transition.
REQ-010 SHALL have port state_ab, output, 2 bits, accepted filtered level {A,B}.

Function
REQ-011 Each channel SHALL pass through a SYNC_STAGES-deep flop chain before any other logic.
REQ-012 Per-channel filter: counter increments each edge the synchronized level differs from the filtered level; on the edge it would reach FILTER_LEN, filtered level takes the new value and counter clears; any edge where levels match clears counter.
REQ-013 Pulses shorter than FILTER_LEN cycles at the synchronizer output SHALL cause no change in state_ab or outputs.
REQ-014 FSM states: INIT, RUN; reset enters INIT.
REQ-015 INIT: filtered levels load without decoding; after FILTER_LEN consecutive edges with both synchronized channels stable, go to RUN; no pulses in INIT.
REQ-016 RUN: on an edge where state_ab changes, decode previous->new: 00->01, 01->11, 11->10, 10->00 = forward; reverse sequence = reverse; both bits changed = illegal.
REQ-017 Forward SHALL assert increase, reverse SHALL assert decrease, illegal SHALL assert error, each registered, high for exactly the cycle after the filtered update.
REQ-018 increase, decrease and error SHALL be mutually exclusive; no pulse when state_ab unchanged.
REQ-019 Latency, stable input in RUN: pulse high after SYNC_STAGES+FILTER_LEN+1 rising edges, counting the edge that first captures the new level (7 with defaults).
REQ-020 en low SHALL force increase/decrease/error to 0 while filtering, state_ab and FSM continue, so re-enabling emits no stale pulse.
REQ-021 Continuous rotation SHALL yield one pulse per accepted edge, up to one per FILTER_LEN+1 cycles; no pulse lost or duplicated.

Reset
REQ-022 rst_n low SHALL asynchronously clear synchronizer flops, filter counters, filtered levels (state_ab = 00), outputs to 0, FSM to INIT.
REQ-023 Reset asserted mid-transition SHALL discard partial filter counts; after release no pulse before INIT completes.
REQ-024 Reset deassertion is synchronous to clk externally; the block SHALL not re-synchronize rst_n.

Structure
REQ-025 Package quadrature_pkg SHALL hold the FSM state typedef (INIT, RUN), the forward-transition table constants and the default SYNC_STAGES/FILTER_LEN values.
REQ-026 Synchronizer plus filter SHALL be sub-module input_filter (params SYNC_STAGES, FILTER_LEN; ports clk, rst_n, din, dout, stable), instantiated once per channel.
REQ-027 Filter counter width SHALL be $clog2(FILTER_LEN+1).

Verification
REQ-028 Reset release with A=1,B=1 held -> state_ab=11 after INIT, no pulse of any kind.
REQ-029 In RUN from 00, drive 01,11,10,00 with 20-cycle holds -> exactly 4 increase pulses, each 7 edges after its input change; decrease=error=0.
REQ-030 Reverse sequence 00,10,11,01,00 -> exactly 4 decrease pulses, increase=0.
REQ-031 3-cycle glitch on enc_a (FILTER_LEN=4) -> no output pulse, state_ab unchanged.
REQ-032 Toggle A and B together from 00 to 11 -> one error pulse, no increase/decrease.
REQ-033 en=0 during two forward steps, then en=1 -> no pulses, state_ab tracks; next forward step yields one increase; rst_n low mid-filter -> outputs 0 immediately.

Source files
------------

// File: rtl/quadrature_pkg.sv
// Shared types and constants for the quadrature decoder: FSM states,
// the forward-step Gray table and default timing parameters.
package quadrature_pkg;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } dec_state_t;

   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_FILTER_LEN  = 4;

   // Forward successor of each {A,B} code, indexed by code*2:
   // 00->01, 01->11, 10->00, 11->10.
   localparam logic [7:0] FWD_TABLE = 8'b10_00_11_01;

   function automatic logic [1:0] fwd_next(input logic [1:0] ab);
      return FWD_TABLE[{ab, 1'b0} +: 2];
   endfunction

endpackage

// File: rtl/input_filter.sv
// One encoder channel: metastability synchronizer followed by a
// persistence filter that only accepts a level held FILTER_LEN cycles.
module input_filter #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout,
   output logic stable
);

   localparam int CW = $clog2(FILTER_LEN + 1);
   localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

   logic [SYNC_STAGES-1:0] sync;
   logic [CW-1:0]          cnt;
   logic                   sync_lvl;

   assign sync_lvl = sync[SYNC_STAGES-1];

   // Stable means nothing is in flight anywhere in the chain.
   assign stable = (sync == {SYNC_STAGES{dout}});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync <= '0;
         cnt  <= '0;
         dout <= 1'b0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], din};
         if (sync_lvl != dout) begin
            if (cnt == LAST) begin
               dout <= sync_lvl;
               cnt  <= '0;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature decoder: filters both encoder channels and emits one-cycle
// increase/decrease/error pulses for each accepted {A,B} transition.
module quadrature_decoder
   import quadrature_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int FILTER_LEN  = DEF_FILTER_LEN
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enc_a,
   input  logic       enc_b,
   input  logic       en,
   output logic       increase,
   output logic       decrease,
   output logic       error,
   output logic [1:0] state_ab
);

   localparam int CW = $clog2(FILTER_LEN + 1);
   localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

   dec_state_t    state;
   logic [CW-1:0] init_cnt;
   logic [1:0]    prev_ab;
   logic          a_filt, b_filt, a_stable, b_stable;

   input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_a (
      .clk(clk), .rst_n(rst_n), .din(enc_a), .dout(a_filt), .stable(a_stable)
   );

   input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_b (
      .clk(clk), .rst_n(rst_n), .din(enc_b), .dout(b_filt), .stable(b_stable)
   );

   assign state_ab = {a_filt, b_filt};

   // prev_ab tracks state_ab in every state, so leaving INIT or
   // re-enabling never sees a stale difference.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= INIT;
         init_cnt <= '0;
         prev_ab  <= 2'b00;
         increase <= 1'b0;
         decrease <= 1'b0;
         error    <= 1'b0;
      end else begin
         prev_ab  <= state_ab;
         increase <= 1'b0;
         decrease <= 1'b0;
         error    <= 1'b0;
         case (state)
            INIT: begin
               if (a_stable && b_stable) begin
                  if (init_cnt == LAST) begin
                     state    <= RUN;
                     init_cnt <= '0;
                  end else begin
                     init_cnt <= init_cnt + CW'(1);
                  end
               end else begin
                  init_cnt <= '0;
               end
            end
            RUN: begin
               if (en && (state_ab != prev_ab)) begin
                  if (state_ab == fwd_next(prev_ab)) begin
                     increase <= 1'b1;
                  end else if (prev_ab == fwd_next(state_ab)) begin
                     decrease <= 1'b1;
                  end else begin
                     error <= 1'b1;
                  end
               end
            end
            default: state <= INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_quadrature_decoder.sv
// Bench for quadrature_decoder: history-based behavioural model checked
// every cycle, plus directed step sequences with literal expectations.
module tb_quadrature_decoder;

   localparam int S  = 2;
   localparam int F  = 4;
   localparam int HL = S + F;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enc_a = 1'b1;
   logic       enc_b = 1'b1;
   logic       en = 1'b1;
   logic       increase, decrease, error;
   logic [1:0] state_ab;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int chg_cyc = 0;
   int last_lat = 0;
   int n_inc = 0, n_dec = 0, n_err = 0;

   quadrature_decoder #(.SYNC_STAGES(S), .FILTER_LEN(F)) dut (
      .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b), .en(en),
      .increase(increase), .decrease(decrease), .error(error),
      .state_ab(state_ab)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Position of a Gray code around the cycle; step direction is the
   // modulo-4 difference of positions.
   function automatic int qpos(input logic [1:0] ab);
      case (ab)
         2'b00:   return 0;
         2'b01:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   logic [1:0] h [0:HL-1];
   logic [1:0] m_ab, m_ab_old;
   logic       m_run;
   int         m_stab;
   logic       e_inc, e_dec, e_err;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ab = 2'b00; m_ab_old = 2'b00; m_run = 1'b0; m_stab = 0;
         e_inc = 1'b0; e_dec = 1'b0; e_err = 1'b0;
         for (int i = 0; i < HL; i++) h[i] = 2'b00;
      end else begin
         logic all_st, win_ok, v;
         e_inc = 1'b0; e_dec = 1'b0; e_err = 1'b0;
         if (m_run && (m_ab != m_ab_old)) begin
            case ((qpos(m_ab) - qpos(m_ab_old)) & 3)
               1:       e_inc = en;
               3:       e_dec = en;
               default: e_err = en;
            endcase
         end
         // h[0] is the sample of the previous edge; h[S-1] reaches the filter now.
         if (!m_run) begin
            all_st = 1'b1;
            for (int i = 0; i < S; i++) if (h[i] != m_ab) all_st = 1'b0;
            if (all_st) begin
               m_stab++;
               if (m_stab == F) m_run = 1'b1;
            end else begin
               m_stab = 0;
            end
         end
         m_ab_old = m_ab;
         for (int c = 0; c < 2; c++) begin
            v = h[S-1][c];
            win_ok = 1'b1;
            for (int j = 0; j < F; j++) if (h[S-1+j][c] != v) win_ok = 1'b0;
            if (win_ok && (v != m_ab[c])) m_ab[c] = v;
         end
         for (int i = HL-1; i > 0; i--) h[i] = h[i-1];
         h[0] = {enc_a, enc_b};
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      check("increase", int'(increase), int'(e_inc));
      check("decrease", int'(decrease), int'(e_dec));
      check("error", int'(error), int'(e_err));
      check("state_ab", int'(state_ab), int'(m_ab));
      if (increase) n_inc++;
      if (decrease) n_dec++;
      if (error) n_err++;
      if (increase || decrease || error) last_lat = cyc - chg_cyc;
   end

   // ---------------- driver tasks ----------------
   task automatic clear_counts();
      n_inc = 0; n_dec = 0; n_err = 0; last_lat = 0;
   endtask

   task automatic step(input logic a, input logic b, input int ei, input int ed, input int ee);
      clear_counts();
      @(negedge clk);
      enc_a = a; enc_b = b; chg_cyc = cyc;
      repeat (20) @(negedge clk);
      check("step_inc_count", n_inc, ei);
      check("step_dec_count", n_dec, ed);
      check("step_err_count", n_err, ee);
      check("step_state_ab", int'(state_ab), int'({a, b}));
      if (ei + ed + ee > 0) check("step_latency", last_lat, 7);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      repeat (3) @(negedge clk);
      check("reset_state_ab", int'(state_ab), 0);
      check("reset_pulses", int'({increase, decrease, error}), 0);
      rst_n = 1'b1;
      clear_counts();
      repeat (30) @(negedge clk);
      check("init_state_ab_11", int'(state_ab), 3);
      check("init_no_pulse", n_inc + n_dec + n_err, 0);

      // back to 00 by forward steps, then a full forward cycle
      step(1'b1, 1'b0, 1, 0, 0);
      step(1'b0, 1'b0, 1, 0, 0);
      step(1'b0, 1'b1, 1, 0, 0);
      step(1'b1, 1'b1, 1, 0, 0);
      step(1'b1, 1'b0, 1, 0, 0);
      step(1'b0, 1'b0, 1, 0, 0);

      // reverse cycle
      step(1'b1, 1'b0, 0, 1, 0);
      step(1'b1, 1'b1, 0, 1, 0);
      step(1'b0, 1'b1, 0, 1, 0);
      step(1'b0, 1'b0, 0, 1, 0);

      // 3-cycle glitch on A
      clear_counts();
      @(negedge clk); enc_a = 1'b1;
      repeat (3) @(negedge clk); enc_a = 1'b0;
      repeat (20) @(negedge clk);
      check("glitch_no_pulse", n_inc + n_dec + n_err, 0);
      check("glitch_state_ab", int'(state_ab), 0);

      // both channels together
      step(1'b1, 1'b1, 0, 0, 1);

      // disabled forward steps, then enabled
      en = 1'b0;
      step(1'b1, 1'b0, 0, 0, 0);
      step(1'b0, 1'b0, 0, 0, 0);
      en = 1'b1;
      step(1'b0, 1'b1, 1, 0, 0);

      // reset while a pulse is high, then re-init with 11 held
      @(negedge clk);
      enc_a = 1'b1; enc_b = 1'b1; chg_cyc = cyc;
      repeat (7) @(posedge clk);
      #1;
      check("pre_reset_inc", int'(increase), 1);
      rst_n = 1'b0;
      #1;
      check("async_reset_inc", int'(increase), 0);
      check("async_reset_state_ab", int'(state_ab), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      clear_counts();
      repeat (30) @(negedge clk);
      check("reinit_state_ab_11", int'(state_ab), 3);
      check("reinit_no_pulse", n_inc + n_dec + n_err, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
